// File: rtl/csa_div_pkg.sv
// Shared types and helpers for the borrow-select restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, the borrow-select column width and the
// iteration-counter width helper.
package csa_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // One borrow-select column per nibble.
  localparam int COL_W = 4;

  // Width of a counter that indexes WIDTH iterations (never below 1 bit).
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/csa_divider_bsu_col.sv
// Borrow-select subtract column: diff = a - b - bin over COL_W bits.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a, b (COL_W-bit operands), bin (borrow in), diff (COL_W-bit result),
// bout (borrow out). Both borrow-in cases are computed up front so the column
// only adds a mux delay once the incoming borrow settles.
module bsu_col
  import csa_div_pkg::*;
(
  input  logic [COL_W-1:0] a,
  input  logic [COL_W-1:0] b,
  input  logic             bin,
  output logic [COL_W-1:0] diff,
  output logic             bout
);

  // Extra top bit of each difference is the borrow out of that case.
  logic [COL_W:0] d_b0;
  logic [COL_W:0] d_b1;

  assign d_b0 = {1'b0, a} - {1'b0, b};
  assign d_b1 = {1'b0, a} - {1'b0, b} - {{COL_W{1'b0}}, 1'b1};

  assign diff = bin ? d_b1[COL_W-1:0] : d_b0[COL_W-1:0];
  assign bout = bin ? d_b1[COL_W]     : d_b0[COL_W];

endmodule

// File: rtl/csa_divider.sv
// Iterative restoring divider, one quotient bit per clock, borrow-select trial subtract.
// Latency: done WIDTH cycles after the accepting edge; divide-by-zero returns off that edge.
// Backpressure: start is only sampled in IDLE/DONE; start during CALC is dropped.
//
// Ports: Clk, Reset (async, active-high), start, dividend, divisor -> busy,
// done (1-cycle pulse), quotient, remainder, div_by_zero. WIDTH must be a
// multiple of 4. Optional macro CSA_DIVIDER_SIGNED_DIV_EN adds input signed_op
// for two's-complement division (truncates toward zero, remainder takes the
// dividend's sign).
module csa_divider
  import csa_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef CSA_DIVIDER_SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  localparam int NCOL = WIDTH / COL_W;
  localparam int CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] d_reg;

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);

  // ---------------- trial subtraction ----------------
  // {R,Q} shifted left: low WIDTH bits go through the columns, R[WIDTH-1]
  // becomes bit WIDTH, R[WIDTH] (always 0 while R < D) sits above it.
  logic [WIDTH-1:0] sh_lo;
  logic [WIDTH:0]   sh_full;
  logic [WIDTH-1:0] trial_lo;
  logic [WIDTH:0]   trial;
  logic [NCOL:0]    bchain;
  logic             borrow;

  assign sh_lo   = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign sh_full = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign bchain[0] = 1'b0;

  for (genvar g = 0; g < NCOL; g++) begin : g_col
    bsu_col u_col (
      .a    (sh_lo[g*COL_W +: COL_W]),
      .b    (d_reg[g*COL_W +: COL_W]),
      .bin  (bchain[g]),
      .diff (trial_lo[g*COL_W +: COL_W]),
      .bout (bchain[g+1])
    );
  end

  // Top borrow bit: the divisor has zeros here, so only the chain borrow ripples up.
  assign trial  = {r_reg[WIDTH-1] ^ bchain[NCOL], trial_lo};
  assign borrow = ~r_reg[WIDTH] & ~r_reg[WIDTH-1] & bchain[NCOL];

  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   r_next;

  assign q_next = {q_reg[WIDTH-2:0], ~borrow};
  assign r_next = borrow ? sh_full : trial;

  // ---------------- operand conditioning / result fix-up ----------------
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             accept;

  assign accept = start & (state != ST_CALC);

`ifdef CSA_DIVIDER_SIGNED_DIV_EN
  logic neg_q, neg_r;
  logic dvd_neg, dvs_neg;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && divisor != '0) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
    end
  end

  // MIN / -1 needs no special case: |MIN| = MIN and negating it gives MIN back.
  assign q_fix = neg_q ? -q_next : q_next;
  assign r_fix = neg_r ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = q_next;
  assign r_fix   = r_next[WIDTH-1:0];
`endif

  // ---------------- control ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (divisor == '0) begin
              // Result is known immediately; skip the iteration phase.
              state       <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_CALC;
              q_reg <= dvd_mag;
              r_reg <= '0;
              d_reg <= dvs_mag;
              count <= '0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state       <= ST_DONE;
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/csa_divider.md
Name: csa_divider

Overview:
- Iterative unsigned restoring divider for the LC-3 datapath; the subtract-side counterpart of the carry-select adder columns.
- Produces one quotient bit per clock.
- Each trial subtraction is built from borrow-select 4-bit columns: both borrow-in cases are precomputed and the result is muxed by the incoming borrow.
- Sits beside the ALU as a multi-cycle functional unit, driven by the control FSM with a start/done handshake.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 (one borrow-select column per nibble).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; latched when start is accepted.
- divisor  input  WIDTH  denominator; latched when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid.
- quotient  output  WIDTH  result; holds until the next accepted start.
- remainder  output  WIDTH  result; holds until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; holds with the results.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, div_by_zero = 0; quotient and remainder = 0; iteration counter = 0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start with divisor!=0. Latch operands: Q=dividend, R=0 (WIDTH+1 bits), D=divisor, count=0.
- IDLE -> DONE on start with divisor==0, with no CALC. Register quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC, once per cycle:
  - Shift {R,Q} left by 1.
  - Compute trial = R_shifted - {0,D} through WIDTH/4 borrow-select columns plus a top borrow bit.
  - No borrow-out: R=trial, Q[0]=1. Otherwise: R restored (shifted value kept), Q[0]=0.
  - count increments.
- CALC -> DONE after iteration WIDTH completes (count==WIDTH-1). Register quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0.
- Latency: done is high exactly WIDTH cycles after the edge that accepts start (divide-by-zero: 1 cycle).
- DONE lasts one cycle, then returns to IDLE. start in DONE is accepted exactly as in IDLE, so back-to-back ops incur no idle cycle.
- start while busy is ignored; latched operands are unaffected.
- Operand inputs may change freely after acceptance.
- done and busy are never high together.
- Outputs update only on the transition into DONE.
- Reset mid-CALC aborts the operation with no done pulse; outputs go to reset values.
- Arithmetic: the remainder register is WIDTH+1 bits so trial subtraction never overflows. The invariant dividend == quotient*divisor + remainder with remainder < divisor must hold for all non-zero divisors.

Optional Feature:
- Macro: CSA_DIVIDER_SIGNED_DIV_EN.
- Defined:
  - Adds input port signed_op (1 bit), latched with start.
  - When signed_op=1, operands are two's complement. Magnitudes are divided unsigned.
  - Quotient is negated when the operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - Sign fix-up is applied on the CALC->DONE transition, so latency is unchanged.
  - Most-negative / -1: quotient=most-negative, remainder=0.
  - Signed divide-by-zero: quotient=all ones, remainder=dividend.
- Undefined: port absent; unsigned only.

Decomposition:
- Package csa_div_pkg:
  - state enum div_state_t (IDLE, CALC, DONE).
  - COL_W=4 localparam.
  - Count-width helper function (clog2 of WIDTH).
- Sub-module bsu_col: one 4-bit borrow-select subtract column.
  - Two 4-bit subtractors, borrow-in 0 and 1.
  - Output mux and borrow-out chosen by the incoming borrow.
  - Instantiated WIDTH/4 times, chained on borrow.

Test Plan:
- Basic unsigned: start with 100/7 -> busy for 16 cycles; done pulse at cycle 16; quotient=14, remainder=2, div_by_zero=0.
- Maximum dividend: 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0. Then 0x1234/0xFFFF -> quotient=0, remainder=0x1234.
- Divide by zero: 0x00AB/0 -> done 1 cycle after start; quotient=0xFFFF, remainder=0x00AB, div_by_zero=1; busy never asserted.
- Handshake: pulse start again at CALC cycle 5 with 9/3 -> ignored; first result 100/7 returned. Start held in DONE with 9/3 -> accepted; result 3 rem 0 exactly 16 cycles later.
- Reset mid-operation: assert Reset at CALC cycle 8 -> outputs 0 immediately (async); no done. A new 50/5 afterwards -> quotient=10, remainder=0.
- Signed (macro defined, signed_op=1): -7/2 -> quotient=0xFFFD (-3), remainder=0xFFFF (-1). 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
